// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the memory-controller pad interface.
//   bus_state_t   : external bus arbitration FSM encodings
//   TA_MAX        : largest supported bus turnaround (idle cycles)
//   ZZ_DLY_MIN/MAX: legal range of suspend cycles before sleep
//   TA_CW/ZZ_CW   : counter widths sized from those limits
package mc_pkg;

    typedef enum logic [1:0] {
        BUS_OWN     = 2'd0,
        BUS_HOLD    = 2'd1,
        BUS_RECLAIM = 2'd2
    } bus_state_t;

    localparam int TA_MAX     = 7;
    localparam int ZZ_DLY_MIN = 1;
    localparam int ZZ_DLY_MAX = 15;

    localparam int TA_CW = $clog2(TA_MAX + 1);
    localparam int ZZ_CW = $clog2(ZZ_DLY_MAX + 1);

endpackage

// File: rtl/mc_br_sync.sv
// mc_br_sync: two-flop synchronizer for the asynchronous bus request.
//   clk, rst_n : clock, async active-low reset (clears both flops)
//   d          : asynchronous input
//   q          : synchronized output, two clk edges after d
module mc_br_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mc_mem_if_p.sv
// mc_mem_if_p: registered memory pad interface with bus arbitration,
// turnaround control and sleep sequencing.
//   inputs : next-cycle address/data/parity and controls, chip-select
//            sources and qualifiers, external bus request mc_br,
//            memory read data/parity.
//   outputs: registered pads (mc_addr, mc_data_o, mc_dp_o, mc_dqm,
//            mc_cs_, mc_oe_, mc_we_, mc_ras_, mc_cas_, mc_data_oe,
//            mc_c_oe), mc_bg/mc_rp/mc_zz, captured read data
//            mc_data_ir, status ta_busy and bus_held.
module mc_mem_if_p
    import mc_pkg::*;
#(
    parameter int NCS    = 8,
    parameter int DW     = 32,
    parameter int AW     = 24,
    parameter int TA     = 1,
    parameter int ZZ_DLY = 4
) (
    input  logic                 mc_clk,
    input  logic                 rst_n,
    input  logic                 mc_br,
    input  logic                 bus_idle,
    input  logic [DW-1:0]        mc_data_od,
    input  logic [DW/8-1:0]      mc_dp_od,
    input  logic [AW-1:0]        mc_addr_d,
    input  logic                 data_oe,
    input  logic                 c_oe_d,
    input  logic                 oe_,
    input  logic                 we_,
    input  logic                 ras_,
    input  logic                 cas_,
    input  logic                 cs_en,
    input  logic                 rfr_ack,
    input  logic                 lmr_sel,
    input  logic                 susp_sel,
    input  logic                 suspended,
    input  logic                 fs,
    input  logic                 rd_cycle,
    input  logic [NCS-1:0]       cs,
    input  logic [NCS-1:0]       cs_need_rfr,
    input  logic [NCS-1:0]       spec_req_cs,
    input  logic [DW/8-1:0]      byte_sel,
    input  logic [DW-1:0]        mc_data_i,
    input  logic [DW/8-1:0]      mc_dp_i,
    output logic [AW-1:0]        mc_addr,
    output logic [DW-1:0]        mc_data_o,
    output logic [DW/8-1:0]      mc_dp_o,
    output logic [DW/8-1:0]      mc_dqm,
    output logic                 mc_data_oe,
    output logic                 mc_c_oe,
    output logic                 mc_oe_,
    output logic                 mc_we_,
    output logic                 mc_ras_,
    output logic                 mc_cas_,
    output logic [NCS-1:0]       mc_cs_,
    output logic                 mc_bg,
    output logic                 mc_rp,
    output logic                 mc_zz,
    output logic [DW+DW/8-1:0]   mc_data_ir,
    output logic                 ta_busy,
    output logic                 bus_held
);

    localparam int PW = DW / 8;
    localparam logic [TA_CW-1:0] TA_LD   = TA_CW'(TA);
    // Last RECLAIM cycle index: TA cycles total, but never less than one.
    localparam logic [TA_CW-1:0] RC_LAST = (TA == 0) ? '0 : TA_CW'(TA - 1);
    localparam logic [ZZ_CW-1:0] ZZ_LD   = ZZ_CW'(ZZ_DLY);

    bus_state_t        state, state_nxt;
    logic              br_s;
    logic [TA_CW-1:0]  ta_cnt;
    logic [TA_CW-1:0]  rc_cnt;
    logic [ZZ_CW-1:0]  zz_cnt;
    logic [NCS-1:0]    cs_sel;
    logic [PW-1:0]     dqm_nxt;
    logic              pad_off;

    mc_br_sync u_br_sync (
        .clk   (mc_clk),
        .rst_n (rst_n),
        .d     (mc_br),
        .q     (br_s)
    );

    // ---------------- bus arbitration FSM ----------------
    always_ff @(posedge mc_clk or negedge rst_n) begin
        if (!rst_n) state <= BUS_OWN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BUS_OWN:     if (br_s && bus_idle)  state_nxt = BUS_HOLD;
            BUS_HOLD:    if (!br_s)             state_nxt = BUS_RECLAIM;
            BUS_RECLAIM: if (rc_cnt == RC_LAST) state_nxt = BUS_OWN;
            default:                            state_nxt = BUS_OWN;
        endcase
    end

    always_ff @(posedge mc_clk or negedge rst_n) begin
        if (!rst_n)                                                rc_cnt <= '0;
        else if (state == BUS_RECLAIM && state_nxt == BUS_RECLAIM) rc_cnt <= rc_cnt + TA_CW'(1);
        else                                                       rc_cnt <= '0;
    end

    assign bus_held = (state != BUS_OWN);
    // Pads are parked while granted away, including the edge that enters
    // HOLD (so cs_ is already high when mc_bg rises) and the edge that
    // leaves RECLAIM.
    assign pad_off  = bus_held || (state_nxt != BUS_OWN);

    // ---------------- turnaround counter ----------------
    always_ff @(posedge mc_clk or negedge rst_n) begin
        if (!rst_n)                   ta_cnt <= '0;
        else if (!mc_oe_ && oe_ && !pad_off) ta_cnt <= TA_LD;
        else if (ta_cnt != '0)        ta_cnt <= ta_cnt - TA_CW'(1);
    end

    assign ta_busy = (ta_cnt != '0);

    // ---------------- sleep counter ----------------
    always_ff @(posedge mc_clk or negedge rst_n) begin
        if (!rst_n)              zz_cnt <= '0;
        else if (!suspended)     zz_cnt <= '0;
        else if (zz_cnt != ZZ_LD) zz_cnt <= zz_cnt + ZZ_CW'(1);
    end

    // ---------------- pad next values ----------------
    always_comb begin
        cs_sel = cs;
        if (rfr_ack || susp_sel) cs_sel = cs_need_rfr;
        else if (lmr_sel)        cs_sel = spec_req_cs;
    end

    always_comb begin
        dqm_nxt = '1;
        if (susp_sel)      dqm_nxt = '1;
        else if (data_oe)  dqm_nxt = ~byte_sel;
        else if (rd_cycle) dqm_nxt = '0;
    end

    always_ff @(posedge mc_clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_addr    <= '0;
            mc_data_o  <= '0;
            mc_dp_o    <= '0;
            mc_dqm     <= '1;
            mc_cs_     <= '1;
            mc_oe_     <= 1'b1;
            mc_we_     <= 1'b1;
            mc_ras_    <= 1'b1;
            mc_cas_    <= 1'b1;
            mc_data_oe <= 1'b0;
            mc_c_oe    <= 1'b0;
            mc_bg      <= 1'b0;
            mc_rp      <= 1'b1;
            mc_zz      <= 1'b0;
        end else begin
            mc_addr    <= mc_addr_d;
            mc_data_o  <= mc_data_od;
            mc_dp_o    <= mc_dp_od;
            mc_dqm     <= dqm_nxt;
            mc_cs_     <= pad_off ? '1 : ~(cs_sel & {NCS{cs_en}});
            mc_oe_     <= oe_  | pad_off;
            mc_we_     <= we_  | pad_off;
            mc_ras_    <= ras_ | pad_off;
            mc_cas_    <= cas_ | pad_off;
            mc_data_oe <= data_oe & !susp_sel & c_oe_d & !ta_busy & !pad_off;
            mc_c_oe    <= c_oe_d & !pad_off;
            mc_bg      <= (state_nxt == BUS_HOLD);
            mc_rp      <= !suspended & !fs;
            mc_zz      <= suspended & (zz_cnt == ZZ_LD);
        end
    end

    // Read capture is a plain data path; no reset needed.
    always_ff @(posedge mc_clk) begin
        mc_data_ir <= {mc_dp_i, mc_data_i};
    end

endmodule

// File: tb/tb_mc_mem_if_p.sv
// tb_mc_mem_if_p: directed-vector bench with an expectation queue.
// Stimulus pushes (cycle, signal, value) entries; a negedge monitor
// pops and compares every entry whose cycle has arrived.
module tb_mc_mem_if_p;

    localparam int NCS = 8, DW = 32, AW = 24, TA = 2, ZZ = 4, PW = DW / 8;

    localparam int S_CS = 0, S_DQM = 1, S_DOE = 2, S_TA = 3, S_BG = 4, S_HELD = 5,
                   S_ZZ = 6, S_RP = 7, S_OE = 8, S_ADDR = 9, S_DIR = 10;

    logic mc_clk = 1'b0;
    logic rst_n, mc_br, bus_idle;
    logic [DW-1:0] mc_data_od, mc_data_i;
    logic [PW-1:0] mc_dp_od, mc_dp_i, byte_sel;
    logic [AW-1:0] mc_addr_d;
    logic data_oe, c_oe_d, oe_, we_, ras_, cas_;
    logic cs_en, rfr_ack, lmr_sel, susp_sel, suspended, fs, rd_cycle;
    logic [NCS-1:0] cs, cs_need_rfr, spec_req_cs;

    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data_o;
    logic [PW-1:0] mc_dp_o, mc_dqm;
    logic mc_data_oe, mc_c_oe, mc_oe_, mc_we_, mc_ras_, mc_cas_;
    logic [NCS-1:0] mc_cs_;
    logic mc_bg, mc_rp, mc_zz, ta_busy, bus_held;
    logic [DW+PW-1:0] mc_data_ir;

    mc_mem_if_p #(.NCS(NCS), .DW(DW), .AW(AW), .TA(TA), .ZZ_DLY(ZZ)) dut (
        .mc_clk(mc_clk), .rst_n(rst_n), .mc_br(mc_br), .bus_idle(bus_idle),
        .mc_data_od(mc_data_od), .mc_dp_od(mc_dp_od), .mc_addr_d(mc_addr_d),
        .data_oe(data_oe), .c_oe_d(c_oe_d), .oe_(oe_), .we_(we_), .ras_(ras_), .cas_(cas_),
        .cs_en(cs_en), .rfr_ack(rfr_ack), .lmr_sel(lmr_sel), .susp_sel(susp_sel),
        .suspended(suspended), .fs(fs), .rd_cycle(rd_cycle),
        .cs(cs), .cs_need_rfr(cs_need_rfr), .spec_req_cs(spec_req_cs),
        .byte_sel(byte_sel), .mc_data_i(mc_data_i), .mc_dp_i(mc_dp_i),
        .mc_addr(mc_addr), .mc_data_o(mc_data_o), .mc_dp_o(mc_dp_o), .mc_dqm(mc_dqm),
        .mc_data_oe(mc_data_oe), .mc_c_oe(mc_c_oe), .mc_oe_(mc_oe_), .mc_we_(mc_we_),
        .mc_ras_(mc_ras_), .mc_cas_(mc_cas_), .mc_cs_(mc_cs_), .mc_bg(mc_bg),
        .mc_rp(mc_rp), .mc_zz(mc_zz), .mc_data_ir(mc_data_ir),
        .ta_busy(ta_busy), .bus_held(bus_held)
    );

    always #5 mc_clk = ~mc_clk;

    typedef struct {
        int          cyc;
        int          id;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge mc_clk) cyc <= cyc + 1;

    function automatic string sig_name(input int id);
        case (id)
            S_CS:   return "mc_cs_";
            S_DQM:  return "mc_dqm";
            S_DOE:  return "mc_data_oe";
            S_TA:   return "ta_busy";
            S_BG:   return "mc_bg";
            S_HELD: return "bus_held";
            S_ZZ:   return "mc_zz";
            S_RP:   return "mc_rp";
            S_OE:   return "mc_oe_";
            S_ADDR: return "mc_addr";
            default: return "mc_data_ir";
        endcase
    endfunction

    function automatic logic [63:0] actual(input int id);
        case (id)
            S_CS:   return 64'(mc_cs_);
            S_DQM:  return 64'(mc_dqm);
            S_DOE:  return 64'(mc_data_oe);
            S_TA:   return 64'(ta_busy);
            S_BG:   return 64'(mc_bg);
            S_HELD: return 64'(bus_held);
            S_ZZ:   return 64'(mc_zz);
            S_RP:   return 64'(mc_rp);
            S_OE:   return 64'(mc_oe_);
            S_ADDR: return 64'(mc_addr);
            default: return 64'(mc_data_ir);
        endcase
    endfunction

    // Expect signal id to equal v after d more rising edges.
    task automatic expect_at(input int id, input logic [63:0] v, input int d);
        exp_t e;
        e.cyc = cyc + d;
        e.id  = id;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge mc_clk);
            #1;
        end
    endtask

    // Monitor
    always @(negedge mc_clk) begin
        int i;
        logic [63:0] act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc <= cyc) begin
                act = actual(q[i].id);
                n_tests++;
                if (act !== q[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got %0h expected %0h",
                             sig_name(q[i].id), cyc, act, q[i].val);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; mc_br = 1'b0; bus_idle = 1'b1;
        mc_data_od = '0; mc_dp_od = '0; mc_addr_d = '0; mc_data_i = '0; mc_dp_i = '0;
        data_oe = 0; c_oe_d = 0; oe_ = 1; we_ = 1; ras_ = 1; cas_ = 1;
        cs_en = 0; rfr_ack = 0; lmr_sel = 0; susp_sel = 0; suspended = 0; fs = 0; rd_cycle = 0;
        cs = '0; cs_need_rfr = '0; spec_req_cs = '0; byte_sel = '0;

        // reset state
        expect_at(S_CS, 64'hFF, 0);   expect_at(S_DQM, 64'hF, 0);
        expect_at(S_DOE, 64'h0, 0);   expect_at(S_BG, 64'h0, 0);
        expect_at(S_ZZ, 64'h0, 0);    expect_at(S_RP, 64'h1, 0);
        expect_at(S_TA, 64'h0, 0);    expect_at(S_HELD, 64'h0, 0);
        expect_at(S_OE, 64'h1, 0);    expect_at(S_ADDR, 64'h0, 0);
        tick(2);
        n_tests++;
        if (mc_cs_ !== 8'hFF) begin
            n_fail++; $display("FAIL mc_cs_ in reset: got %0h", mc_cs_);
        end
        n_tests++;
        if (mc_dqm !== 4'hF) begin
            n_fail++; $display("FAIL mc_dqm in reset: got %0h", mc_dqm);
        end
        n_tests++;
        if (bus_held !== 1'b0) begin
            n_fail++; $display("FAIL bus_held in reset: got %0h", bus_held);
        end
        rst_n = 1'b1;
        tick();

        // chip-select priority
        cs = 8'h04; cs_en = 1;           expect_at(S_CS, 64'hFB, 1); tick();
        rfr_ack = 1; cs_need_rfr = 8'hFF; expect_at(S_CS, 64'h00, 1); tick();
        rfr_ack = 0; lmr_sel = 1; spec_req_cs = 8'h30;
                                          expect_at(S_CS, 64'hCF, 1); tick();
        cs_en = 0;                        expect_at(S_CS, 64'hFF, 1); tick();
        lmr_sel = 0; cs_en = 1;

        // address and read capture
        mc_addr_d = 24'h123456; mc_data_i = 32'hDEADBEEF; mc_dp_i = 4'hA;
        expect_at(S_ADDR, 64'h123456, 1); expect_at(S_DIR, 64'hA_DEADBEEF, 1); tick();

        // byte mask
        data_oe = 1; byte_sel = 4'b0011;
        expect_at(S_DQM, 64'hC, 1); expect_at(S_DOE, 64'h0, 1); tick();
        susp_sel = 1;                 expect_at(S_DQM, 64'hF, 1); tick();
        susp_sel = 0; data_oe = 0; rd_cycle = 1; expect_at(S_DQM, 64'h0, 1); tick();
        rd_cycle = 0;                 expect_at(S_DQM, 64'hF, 1); tick();

        // read then write, TA=2
        oe_ = 0; expect_at(S_OE, 64'h0, 1); tick();
        oe_ = 1; expect_at(S_TA, 64'h1, 1); tick();
        data_oe = 1; c_oe_d = 1;
        expect_at(S_DOE, 64'h0, 1); expect_at(S_DOE, 64'h0, 2); expect_at(S_DOE, 64'h1, 3);
        expect_at(S_TA, 64'h1, 1);  expect_at(S_TA, 64'h0, 2);
        tick(3);
        data_oe = 0; c_oe_d = 0; tick();

        // grant held off while controller busy
        bus_idle = 0; mc_br = 1;
        for (int k = 1; k <= 5; k++) expect_at(S_BG, 64'h0, k);
        tick(5);
        bus_idle = 1;
        expect_at(S_BG, 64'h1, 1); expect_at(S_CS, 64'hFF, 1); expect_at(S_HELD, 64'h1, 1);
        tick(2);
        mc_br = 0;
        expect_at(S_BG, 64'h1, 2); expect_at(S_BG, 64'h0, 3);
        expect_at(S_HELD, 64'h1, 4); expect_at(S_CS, 64'hFF, 4);
        expect_at(S_HELD, 64'h0, 5); expect_at(S_CS, 64'hFB, 6);
        tick(7);

        // sleep
        suspended = 1;
        expect_at(S_RP, 64'h0, 1); expect_at(S_ZZ, 64'h0, 4); expect_at(S_ZZ, 64'h1, 5);
        tick(6);
        suspended = 0; expect_at(S_ZZ, 64'h0, 1); expect_at(S_RP, 64'h1, 1); tick();
        fs = 1;        expect_at(S_RP, 64'h0, 1); tick();
        fs = 0; tick();

        // reset while granted, then re-grant
        mc_br = 1; expect_at(S_BG, 64'h1, 3); tick(4);
        rst_n = 0;
        #1;
        n_tests++;
        if (mc_bg !== 1'b0) begin
            n_fail++; $display("FAIL mc_bg async reset: got %0h", mc_bg);
        end
        n_tests++;
        if (mc_cs_ !== 8'hFF) begin
            n_fail++; $display("FAIL mc_cs_ async reset: got %0h", mc_cs_);
        end
        expect_at(S_BG, 64'h0, 0); expect_at(S_CS, 64'hFF, 0); expect_at(S_HELD, 64'h0, 0);
        tick(2);
        rst_n = 1;
        expect_at(S_BG, 64'h0, 2); expect_at(S_BG, 64'h1, 3);
        tick(4);
        mc_br = 0;
        tick(8);

        foreach (q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cyc %0d never checked", sig_name(q[i].id), q[i].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_mem_if_p.md
MC_MEM_IF_P -- requirements
Module: mc_mem_if_p

Interface
REQ-001 Parameter NCS, default 8: number of chip selects (1..8).
REQ-002 Parameter DW, default 32: data width; parity width DW/8.
REQ-003 Parameter AW, default 24: memory address width.
REQ-004 Parameter TA, default 1: bus turnaround idle cycles (0..7).
REQ-005 Parameter ZZ_DLY, default 4: suspend cycles before sleep (1..15).
REQ-006 Clocking and reset: one clock, mc_clk; reset rst_n, asynchronous, active-low.
REQ-007 mc_clk  in  1  memory-side clock; all registers on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 mc_br  in  1  external bus request, asynchronous.
REQ-010 bus_idle  in  1  controller has no memory cycle in progress.
REQ-011 mc_data_od, mc_dp_od, mc_addr_d  in  DW, DW/8, AW  next data, parity and address.
REQ-012 data_oe, c_oe_d, oe_, we_, ras_, cas_  in  1 each  next-cycle controls (oe_, we_, ras_ and cas_ are active-low).
REQ-013 cs_en, rfr_ack, lmr_sel, susp_sel, suspended, fs, rd_cycle  in  1 each  selection and mode qualifiers.
REQ-014 cs, cs_need_rfr, spec_req_cs  in  NCS each  normal, refresh and load-mode chip selects.
REQ-015 byte_sel  in  DW/8  write byte enables.
REQ-016 mc_data_i, mc_dp_i  in  DW, DW/8  memory read data and parity.
REQ-017 mc_addr, mc_data_o, mc_dp_o, mc_dqm  out  AW, DW, DW/8, DW/8  registered pad outputs.
REQ-018 mc_data_oe, mc_c_oe, mc_oe_, mc_we_, mc_ras_, mc_cas_  out  1 each  registered pad controls.
REQ-019 mc_cs_  out  NCS  active-low chip selects.
REQ-020 mc_bg, mc_rp, mc_zz  out  1 each  bus grant, reset/power-down pin, sleep.
REQ-021 mc_data_ir  out  DW+DW/8  registered {mc_dp_i, mc_data_i}.
REQ-022 ta_busy, bus_held  out  1 each  turnaround active; bus granted away.

Function
REQ-023 Every pad output is driven from a register; latency from the *_d/control inputs to the pad is 1 mc_clk.
REQ-024 Chip-select source priority: (rfr_ack|susp_sel) selects cs_need_rfr; else lmr_sel selects spec_req_cs; else cs. The selection is ANDed with cs_en, then inverted.
REQ-025 mc_dqm takes all-ones if susp_sel; else ~byte_sel if data_oe; else all-zeros if rd_cycle; else all-ones.
REQ-026 The turnaround counter loads TA on the cycle mc_oe_ goes 0->1 and decrements to 0; ta_busy = (counter != 0).
REQ-027 mc_data_oe <= data_oe & !susp_sel & c_oe_d & !ta_busy & !bus_held. With TA=0, a write may follow a read back-to-back.
REQ-028 mc_br passes through a 2-flop synchronizer (br_s) before the bus FSM uses it.
REQ-029 Bus FSM states are OWN, HOLD and RECLAIM.
REQ-030 OWN->HOLD when br_s & bus_idle. OWN is held while !bus_idle, even if br_s is set.
REQ-031 HOLD->RECLAIM when !br_s.
REQ-032 RECLAIM->OWN after TA cycles; with TA=0, RECLAIM lasts exactly 1 cycle.
REQ-033 mc_bg = 1 only in HOLD, registered; bus_held = 1 in HOLD and RECLAIM.
REQ-034 While bus_held: mc_cs_ all ones; mc_oe_, mc_we_, mc_ras_ and mc_cas_ at 1; mc_data_oe and mc_c_oe at 0.
REQ-035 A br_s assertion during RECLAIM returns the FSM to HOLD only after it reaches OWN and REQ-030 holds.
REQ-036 Sleep counter: increments while suspended and saturates at ZZ_DLY; mc_zz = 1 when the count equals ZZ_DLY; a cleared suspended zeroes the counter and drops mc_zz on the next edge.
REQ-037 mc_rp <= !suspended & !fs.
REQ-038 mc_data_ir samples every cycle and has no reset.

Reset
REQ-039 While rst_n=0: mc_cs_ all ones; mc_oe_, mc_we_, mc_ras_, mc_cas_ and mc_rp at 1; mc_data_oe, mc_c_oe, mc_bg, mc_zz, ta_busy and bus_held at 0; mc_dqm all ones; mc_addr, mc_data_o and mc_dp_o at 0; FSM in OWN; counters and synchronizer at 0.
REQ-040 An assertion mid-grant forces OWN immediately; after release, a still-high mc_br re-grants via REQ-030.

Structure
REQ-041 FSM state encodings and the TA/ZZ_DLY range limits live in the shared package mc_pkg.
REQ-042 One sub-module, mc_br_sync (a 2-flop synchronizer), is instantiated for mc_br.

Verification
REQ-043 Direct CS: cs=8'h04, cs_en=1, no qualifiers -> mc_cs_=8'hFB one cycle later. Adding rfr_ack=1 with cs_need_rfr=8'hFF -> mc_cs_=8'h00.
REQ-044 Read then write with TA=2: oe_ 0->1, data_oe=1 the next cycle -> mc_data_oe stays 0 for 2 cycles with ta_busy=1, then goes 1.
REQ-045 Grant: mc_br=1 while bus_idle=0 for 5 cycles -> mc_bg stays 0. bus_idle=1 -> mc_bg=1 within 4 cycles and all mc_cs_ high. mc_br=0 -> mc_bg=0, then OWN after TA cycles.
REQ-046 Sleep: suspended=1 for ZZ_DLY=4 -> mc_zz=1 on the 5th edge. suspended=0 -> mc_zz=0 next edge; mc_rp follows !suspended.
REQ-047 Byte mask: data_oe=1, byte_sel=4'b0011 -> mc_dqm=4'b1100. susp_sel=1 -> 4'hF.
REQ-048 Reset pulse while in HOLD -> mc_bg=0 and mc_cs_=all ones asynchronously; re-grant follows REQ-030 after release.
